// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the multi-port RV32IM register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRP_DEF   = 2;
    localparam int ZERO_REG  = 0;

    typedef enum logic {
        RF_INIT,
        RF_READY
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of read, writeback, issue and debug signals for the register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRP   = NRP_DEF
);
    localparam int AW = $clog2(NREGS);

    logic                ready;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic [NREGS-1:0]    busy_vec;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;

    modport master (
        input  ready, rd_data, rd_busy, busy_vec, dbg_data,
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, dbg_addr
    );

    modport slave (
        output ready, rd_data, rd_busy, busy_vec, dbg_data,
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, dbg_addr
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags: issue sets, writeback clears, issue wins on a collision.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     set_en,
    input  logic [$clog2(NREGS)-1:0] set_addr,
    input  logic                     clr_en,
    input  logic [$clog2(NREGS)-1:0] clr_addr,
    output logic [NREGS-1:0]         busy
);
    logic [NREGS-1:0] busy_next;

    // Clear is applied before set so a same-cycle issue leaves the bit set.
    always_comb begin
        busy_next = busy;
        if (clr_en) busy_next[clr_addr] = 1'b0;
        if (set_en) busy_next[set_addr] = 1'b1;
        busy_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      busy <= '0;
        else if (enable) busy <= busy_next;
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with clear sweep and busy scoreboard.
// Optional same-cycle write forwarding to read ports: define REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRP   = NRP_DEF
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic [XLEN-1:0] regs [NREGS];
    logic            is_ready;
    logic [NREGS-1:0] busy;
    logic [NRP*XLEN-1:0] rd_data_c;
    logic [NRP-1:0]      rd_busy_c;

    assign is_ready = (state_q == RF_READY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RF_INIT;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == RF_INIT) begin
            if (clr_idx_q == LAST_IDX) state_d   = RF_READY;
            else                       clr_idx_d = clr_idx_q + 1'b1;
        end
    end

    // Storage has no reset so it can map onto distributed RAM; the sweep clears it.
    always_ff @(posedge clk) begin
        if (state_q == RF_INIT)
            regs[clr_idx_q] <= '0;
        else if (bus.wr_en && bus.wr_addr != ZERO_IDX)
            regs[bus.wr_addr] <= bus.wr_data;
    end

    regfile_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (is_ready),
        .set_en   (bus.iss_en),
        .set_addr (bus.iss_addr),
        .clr_en   (bus.wr_en),
        .clr_addr (bus.wr_addr),
        .busy     (busy)
    );

    always_comb begin
        logic [AW-1:0] addr;
        rd_data_c = '0;
        rd_busy_c = '0;
        addr      = '0;
        for (int i = 0; i < NRP; i++) begin
            addr = bus.rd_addr[i*AW +: AW];
            if (is_ready && addr != ZERO_IDX)
                rd_data_c[i*XLEN +: XLEN] = regs[addr];
            rd_busy_c[i] = busy[addr];
`ifdef REGFILE_BYPASS_EN
            if (is_ready && bus.wr_en && bus.wr_addr != ZERO_IDX && bus.wr_addr == addr) begin
                rd_data_c[i*XLEN +: XLEN] = bus.wr_data;
                if (!(bus.iss_en && bus.iss_addr == addr))
                    rd_busy_c[i] = 1'b0;
            end
`endif
        end
    end

    assign bus.ready    = is_ready;
    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.busy_vec = busy;
    assign bus.dbg_data = (is_ready && bus.dbg_addr != ZERO_IDX) ? regs[bus.dbg_addr] : '0;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic against an array model.
module tb_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRP   = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_regs [NREGS];
    logic [31:0] m_busy;
    int          m_edges;
    logic        m_ready;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
        m_busy  = '0;
        m_edges = 0;
        m_ready = 1'b0;
    endtask

    function automatic logic [31:0] expData(input logic [AW-1:0] a);
        logic [31:0] v;
        v = (m_ready && a != 0) ? m_regs[a] : 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (m_ready && bus.wr_en && bus.wr_addr != 0 && bus.wr_addr == a) v = bus.wr_data;
`endif
        return v;
    endfunction

    function automatic logic expBusy(input logic [AW-1:0] a);
        logic b;
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (m_ready && bus.wr_en && bus.wr_addr != 0 && bus.wr_addr == a &&
            !(bus.iss_en && bus.iss_addr == a)) b = 1'b0;
`endif
        return b;
    endfunction

    // One clock of traffic: drive at negedge, check outputs, then advance the model at posedge.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                                 input logic ie, input logic [AW-1:0] ia,
                                 input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                                 input logic [AW-1:0] da);
        @(negedge clk);
        bus.wr_en    = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.iss_en   = ie;
        bus.iss_addr = ia;
        bus.rd_addr  = {r1, r0};
        bus.dbg_addr = da;
        #1;
        checkOutput("ready",    {31'b0, bus.ready},      {31'b0, m_ready});
        checkOutput("rd_data0", bus.rd_data[31:0],       expData(r0));
        checkOutput("rd_data1", bus.rd_data[63:32],      expData(r1));
        checkOutput("rd_busy0", {31'b0, bus.rd_busy[0]}, {31'b0, expBusy(r0)});
        checkOutput("rd_busy1", {31'b0, bus.rd_busy[1]}, {31'b0, expBusy(r1)});
        checkOutput("busy_vec", bus.busy_vec,            m_busy);
        checkOutput("dbg_data", bus.dbg_data,            (m_ready && da != 0) ? m_regs[da] : 32'h0);
        @(posedge clk);
        if (m_ready) begin
            if (we && wa != 0) begin
                m_regs[wa] = wd;
                m_busy[wa] = 1'b0;
            end
            if (ie && ia != 0) m_busy[ia] = 1'b1;
        end else begin
            m_edges++;
            m_ready = (m_edges >= NREGS);
        end
    endtask

    task automatic idle(input int n, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, '0, 1'b0, '0, r0, r1, r0);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0; bus.rd_addr = '0; bus.dbg_addr = '0;
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_ready",    {31'b0, bus.ready}, 32'h0);
        checkOutput("rst_busy_vec", bus.busy_vec,       32'h0);
        checkOutput("rst_rd_busy",  {30'b0, bus.rd_busy}, 32'h0);
        checkOutput("rst_rd_data0", bus.rd_data[31:0],  32'h0);
        checkOutput("rst_dbg_data", bus.dbg_data,       32'h0);

        @(posedge clk); #1 rst_n = 1'b1;
        $display("[TB] reset released, clear sweep running");
        // Writes and issues during the sweep must be ignored.
        applyStimulus(1'b1, 5'd4, 32'hFFFF0000, 1'b1, 5'd4, 5'd1, 5'd31, 5'd4);
        idle(NREGS + 1, 5'd1, 5'd31);

        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd5, 5'd5, 5'd5);
        idle(1, 5'd5, 5'd5);
        applyStimulus(1'b1, 5'd0, 32'h00001234, 1'b1, 5'd0, 5'd0, 5'd5, 5'd0);
        idle(1, 5'd0, 5'd0);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd6, 5'd7);
        applyStimulus(1'b1, 5'd7, 32'h77777777, 1'b1, 5'd7, 5'd7, 5'd6, 5'd7);
        applyStimulus(1'b1, 5'd7, 32'h70707070, 1'b0, '0, 5'd7, 5'd7, 5'd7);
        idle(1, 5'd7, 5'd5);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd2, 5'd3);
        applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, '0, 5'd3, 5'd3, 5'd3);
        idle(1, 5'd3, 5'd2);

        for (int k = 0; k < 300; k++) begin
            logic [AW-1:0] lim;
            lim = ($urandom_range(0, 3) == 0) ? 5'd3 : 5'd31;
            applyStimulus($urandom_range(0, 1) == 1, AW'($urandom_range(0, lim)), $urandom,
                          $urandom_range(0, 2) == 0, AW'($urandom_range(0, lim)),
                          AW'($urandom_range(0, lim)), AW'($urandom_range(0, lim)),
                          AW'($urandom_range(0, 31)));
        end

        applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd1, 5'd9);
        applyStimulus(1'b1, 5'd9, 32'h99999999, 1'b0, '0, 5'd9, 5'd1, 5'd9);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd1, 5'd9);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready",    {31'b0, bus.ready}, 32'h0);
        checkOutput("midrst_busy_vec", bus.busy_vec,       32'h0);
        modelReset();
        @(posedge clk); #1 rst_n = 1'b1;
        $display("[TB] mid-stream reset released, second sweep running");
        idle(NREGS + 2, 5'd9, 5'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
